// File: rtl/pic_pkg.sv
// Shared constants, state type and rank helper for the PIC priority resolver.
package pic_pkg;

   localparam int PIC_NUM_IR = 8;
   localparam int PIC_IDX_W  = 3;

   localparam logic [PIC_IDX_W-1:0] PIC_SPURIOUS_IDX = 3'd7;
   localparam logic [PIC_IDX_W-1:0] PIC_RESET_LOWEST = 3'd7;

   typedef enum logic {PR_IDLE, PR_ACK} pr_state_e;

   // Position of idx in the rotated order starting at base+1; 0 = highest priority.
   function automatic logic [PIC_IDX_W-1:0] pic_rank(input logic [PIC_IDX_W-1:0] idx,
                                                     input logic [PIC_IDX_W-1:0] base);
      return idx - base - 3'd1;
   endfunction

endpackage

// File: rtl/pic_rotate_find_first.sv
// First set bit of an 8-bit vector, scanning upward from base+1 and wrapping mod 8.
module pic_rotate_find_first
   import pic_pkg::*;
(
   input  logic [PIC_NUM_IR-1:0] vector,
   input  logic [PIC_IDX_W-1:0]  base,
   output logic                  found,
   output logic [PIC_IDX_W-1:0]  idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= PIC_NUM_IR; k++) begin
         if (!found && vector[base + PIC_IDX_W'(k)]) begin
            found = 1'b1;
            idx   = base + PIC_IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/pic_priority_resolver.sv
// 8259 request capture, masking and rotating-priority resolve, with the INTA
// handshake that freezes the resolved level between ack1 and ack2.
module pic_priority_resolver
   import pic_pkg::*;
#(
   parameter int                   NUM_IR       = PIC_NUM_IR,
   parameter logic [PIC_IDX_W-1:0] RESET_LOWEST = PIC_RESET_LOWEST
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_IR-1:0]    ir_in,
   input  logic                 ltim,
   input  logic [NUM_IR-1:0]    imr,
   input  logic [NUM_IR-1:0]    isr,
   input  logic                 special_mask_mode,
   input  logic                 ack1,
   input  logic                 ack2,
   input  logic                 rotate_cmd,
   input  logic                 rotate_specific,
   input  logic [PIC_IDX_W-1:0] rotate_level,
   input  logic [PIC_IDX_W-1:0] eoi_idx,
   input  logic                 aeoi_rotate,
   output logic [NUM_IR-1:0]    irr,
   output logic                 int_req,
   output logic [PIC_IDX_W-1:0] highest_priority_idx,
   output logic [PIC_IDX_W-1:0] lowest_priority,
   output logic                 in_ack
);

   pr_state_e              state_q;
   logic [NUM_IR-1:0]      irr_q, irr_d, ir_prev_q;
   logic                   int_req_q, in_ack_q, spurious_q;
   logic [PIC_IDX_W-1:0]   hpi_q, lowest_q, lowest_d;

   logic                   req_found, isr_found, valid;
   logic [PIC_IDX_W-1:0]   req_idx, isr_idx;
   logic                   take_ack, aeoi_fire;

   pic_rotate_find_first u_req_scan (
      .vector (irr_q & ~imr),
      .base   (lowest_q),
      .found  (req_found),
      .idx    (req_idx)
   );

   pic_rotate_find_first u_isr_scan (
      .vector (isr),
      .base   (lowest_q),
      .found  (isr_found),
      .idx    (isr_idx)
   );

   // Normal mode: the highest in-service level blocks everything at or below it.
   always_comb begin
      if (special_mask_mode)
         valid = req_found && !isr[req_idx];
      else
         valid = req_found && (!isr_found ||
                 (pic_rank(req_idx, lowest_q) < pic_rank(isr_idx, lowest_q)));
   end

   assign take_ack  = (state_q == PR_IDLE) && ack1 && int_req_q;
   assign aeoi_fire = (state_q == PR_ACK) && ack2 && aeoi_rotate && !spurious_q;

   // A granted level is dropped for one cycle; level lines reload it afterwards.
   always_comb begin
      irr_d = ltim ? ir_in : ((irr_q | (ir_in & ~ir_prev_q)) & ir_in);
      if (take_ack)
         irr_d[hpi_q] = 1'b0;
   end

   always_comb begin
      lowest_d = lowest_q;
      if (rotate_cmd)
         lowest_d = rotate_specific ? rotate_level : eoi_idx;
      else if (aeoi_fire)
         lowest_d = hpi_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= PR_IDLE;
         irr_q      <= '0;
         ir_prev_q  <= '1;
         int_req_q  <= 1'b0;
         hpi_q      <= '0;
         lowest_q   <= RESET_LOWEST;
         in_ack_q   <= 1'b0;
         spurious_q <= 1'b0;
      end else begin
         irr_q     <= irr_d;
         ir_prev_q <= ir_in;
         lowest_q  <= lowest_d;
         case (state_q)
            PR_IDLE: begin
               if (ack1) begin
                  int_req_q  <= 1'b0;
                  in_ack_q   <= 1'b1;
                  spurious_q <= !int_req_q;
                  state_q    <= PR_ACK;
                  if (!int_req_q)
                     hpi_q <= PIC_SPURIOUS_IDX;
               end else begin
                  int_req_q <= valid;
                  if (valid)
                     hpi_q <= req_idx;
               end
            end
            PR_ACK: begin
               int_req_q <= 1'b0;
               if (ack2) begin
                  in_ack_q <= 1'b0;
                  state_q  <= PR_IDLE;
               end
            end
            default: state_q <= PR_IDLE;
         endcase
      end
   end

   assign irr                  = irr_q;
   assign int_req              = int_req_q;
   assign highest_priority_idx = hpi_q;
   assign lowest_priority      = lowest_q;
   assign in_ack               = in_ack_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_pic_priority_resolver;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ir_in, imr, isr;
   logic       ltim, special_mask_mode, ack1, ack2, rotate_cmd, rotate_specific, aeoi_rotate;
   logic [2:0] rotate_level, eoi_idx;
   logic [7:0] irr;
   logic       int_req, in_ack;
   logic [2:0] highest_priority_idx, lowest_priority;

   int tests_run = 0;
   int tests_failed = 0;

   // reference model state
   logic [7:0] m_irr, m_prev;
   logic [2:0] m_L, m_idx;
   logic       m_int, m_inack, m_busy, m_spur;

   pic_priority_resolver dut (
      .clk(clk), .rst(rst), .ir_in(ir_in), .ltim(ltim), .imr(imr), .isr(isr),
      .special_mask_mode(special_mask_mode), .ack1(ack1), .ack2(ack2),
      .rotate_cmd(rotate_cmd), .rotate_specific(rotate_specific),
      .rotate_level(rotate_level), .eoi_idx(eoi_idx), .aeoi_rotate(aeoi_rotate),
      .irr(irr), .int_req(int_req), .highest_priority_idx(highest_priority_idx),
      .lowest_priority(lowest_priority), .in_ack(in_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic int rk(int i, int L);
      return (i - L - 1 + 16) % 8;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      logic [7:0] cand, nirr;
      int p;
      bit v, aeoi;
      if (rst) begin
         m_irr = 0; m_prev = 8'hFF; m_L = 3'd7; m_idx = 0;
         m_int = 0; m_inack = 0; m_busy = 0; m_spur = 0;
         return;
      end
      cand = m_irr & ~imr;
      p = -1;
      for (int r = 0; r < 8; r++)
         if (p < 0 && cand[(int'(m_L) + 1 + r) % 8]) p = (int'(m_L) + 1 + r) % 8;
      v = (p >= 0);
      if (v) begin
         if (special_mask_mode) v = !isr[p];
         else
            for (int j = 0; j < 8; j++)
               if (isr[j] && rk(j, int'(m_L)) <= rk(p, int'(m_L))) v = 0;
      end
      for (int i = 0; i < 8; i++)
         nirr[i] = ltim ? ir_in[i] : ((m_irr[i] || (ir_in[i] && !m_prev[i])) && ir_in[i]);
      aeoi = 0;
      if (!m_busy) begin
         if (ack1) begin
            if (m_int) nirr[m_idx] = 1'b0;
            else m_idx = 3'd7;
            m_spur = !m_int; m_int = 0; m_inack = 1; m_busy = 1;
         end else begin
            m_int = v;
            if (v) m_idx = 3'(p);
         end
      end else if (ack2) begin
         m_busy = 0; m_inack = 0; aeoi = aeoi_rotate && !m_spur;
      end
      if (rotate_cmd) m_L = rotate_specific ? rotate_level : eoi_idx;
      else if (aeoi) m_L = m_idx;
      m_irr = nirr;
      m_prev = ir_in;
   endtask

   task automatic test_reset();
      rst = 1; ir_in = 8'h80;
      tick(); tick();
      tests_run++;
      if ({irr, int_req, highest_priority_idx, lowest_priority, in_ack} !== {8'h00, 1'b0, 3'd0, 3'd7, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_values: got irr=%h int=%b idx=%0d L=%0d ack=%b, expected 00 0 0 7 0",
                  irr, int_req, highest_priority_idx, lowest_priority, in_ack);
      end
      rst = 0;
      tick(); tick(); tick();
      tests_run++;
      if ({irr, int_req} !== 9'h000) begin
         tests_failed++;
         $display("FAIL high_at_reset_no_latch: got irr=%h int=%b, expected 00 0", irr, int_req);
      end
      ir_in = 0;
      tick();
   endtask

   task automatic test_edge_basic();
      ir_in = 8'h24;
      tick();
      tests_run++;
      if (irr !== 8'h24 || int_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL edge_irr_latency: got irr=%h int=%b, expected 24 0", irr, int_req);
      end
      tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd2) begin
         tests_failed++;
         $display("FAIL edge_int_req: got int=%b idx=%0d, expected 1 2", int_req, highest_priority_idx);
      end
      ack1 = 1; tick(); ack1 = 0;
      tests_run++;
      if ({irr, int_req, in_ack, highest_priority_idx} !== {8'h20, 1'b0, 1'b1, 3'd2}) begin
         tests_failed++;
         $display("FAIL ack1_grant: got irr=%h int=%b ack=%b idx=%0d, expected 20 0 1 2",
                  irr, int_req, in_ack, highest_priority_idx);
      end
      tick(); tick();
      tests_run++;
      if (int_req !== 1'b0 || highest_priority_idx !== 3'd2) begin
         tests_failed++;
         $display("FAIL ack_frozen: got int=%b idx=%0d, expected 0 2", int_req, highest_priority_idx);
      end
      ack2 = 1; tick(); ack2 = 0;
      tests_run++;
      if (in_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL ack2_release: got in_ack=%b, expected 0", in_ack);
      end
      tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd5) begin
         tests_failed++;
         $display("FAIL next_request: got int=%b idx=%0d, expected 1 5", int_req, highest_priority_idx);
      end
      ir_in = 0; tick(); tick();
      tests_run++;
      if (irr !== 8'h00 || int_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL edge_drop_lost: got irr=%h int=%b, expected 00 0", irr, int_req);
      end
   endtask

   task automatic test_isr_block_smm();
      isr = 8'h04; ir_in = 8'h09;
      tick(); tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL isr_higher_granted: got int=%b idx=%0d, expected 1 0", int_req, highest_priority_idx);
      end
      ir_in = 8'h08; tick(); tick();
      tests_run++;
      if (int_req !== 1'b0 || highest_priority_idx !== 3'd0) begin
         tests_failed++;
         $display("FAIL isr_blocks_lower: got int=%b idx=%0d, expected 0 0", int_req, highest_priority_idx);
      end
      special_mask_mode = 1; isr = 8'h01; tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd3) begin
         tests_failed++;
         $display("FAIL smm_unblock: got int=%b idx=%0d, expected 1 3", int_req, highest_priority_idx);
      end
      ir_in = 0; special_mask_mode = 0; isr = 0;
      tick(); tick();
   endtask

   task automatic test_masked_spurious();
      rotate_cmd = 1; rotate_specific = 1; rotate_level = 3'd2; tick(); rotate_cmd = 0;
      tests_run++;
      if (lowest_priority !== 3'd2) begin
         tests_failed++;
         $display("FAIL rotate_to_2: got L=%0d, expected 2", lowest_priority);
      end
      imr = 8'h01; ir_in = 8'h01; aeoi_rotate = 1;
      tick(); tick();
      tests_run++;
      if (int_req !== 1'b0 || irr !== 8'h01) begin
         tests_failed++;
         $display("FAIL masked_no_int: got int=%b irr=%h, expected 0 01", int_req, irr);
      end
      ack1 = 1; tick(); ack1 = 0;
      tests_run++;
      if (highest_priority_idx !== 3'd7 || irr !== 8'h01 || int_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL spurious_ack1: got idx=%0d irr=%h int=%b, expected 7 01 0",
                  highest_priority_idx, irr, int_req);
      end
      ack2 = 1; tick(); ack2 = 0;
      tests_run++;
      if (in_ack !== 1'b0 || lowest_priority !== 3'd2) begin
         tests_failed++;
         $display("FAIL spurious_no_aeoi: got ack=%b L=%0d, expected 0 2", in_ack, lowest_priority);
      end
      ir_in = 0; tick();
      imr = 0; aeoi_rotate = 0; tick();
   endtask

   task automatic test_rotate_specific();
      rotate_cmd = 1; rotate_specific = 1; rotate_level = 3'd3; tick(); rotate_cmd = 0;
      ir_in = 8'h11; tick(); tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd4 || lowest_priority !== 3'd3) begin
         tests_failed++;
         $display("FAIL rotated_order: got int=%b idx=%0d L=%0d, expected 1 4 3",
                  int_req, highest_priority_idx, lowest_priority);
      end
      ack1 = 1; tick(); ack1 = 0;
      ack2 = 1; tick(); ack2 = 0;
      tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd0 || irr !== 8'h01) begin
         tests_failed++;
         $display("FAIL rotated_second: got int=%b idx=%0d irr=%h, expected 1 0 01",
                  int_req, highest_priority_idx, irr);
      end
      ack1 = 1; tick(); ack1 = 0;
      ack2 = 1; tick(); ack2 = 0;
      ir_in = 0; tick(); tick();
   endtask

   task automatic test_aeoi_rotate();
      aeoi_rotate = 1; ir_in = 8'h20;
      tick(); tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd5) begin
         tests_failed++;
         $display("FAIL aeoi_req: got int=%b idx=%0d, expected 1 5", int_req, highest_priority_idx);
      end
      ack1 = 1; tick(); ack1 = 0;
      ack2 = 1; tick(); ack2 = 0;
      tests_run++;
      if (lowest_priority !== 3'd5 || in_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL aeoi_rotate: got L=%0d ack=%b, expected 5 0", lowest_priority, in_ack);
      end
      ir_in = 8'h60; tick(); tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd6) begin
         tests_failed++;
         $display("FAIL aeoi_second_req: got int=%b idx=%0d, expected 1 6", int_req, highest_priority_idx);
      end
      ack1 = 1; tick(); ack1 = 0;
      ack2 = 1; rotate_cmd = 1; rotate_specific = 0; eoi_idx = 3'd1;
      tick();
      ack2 = 0; rotate_cmd = 0;
      tests_run++;
      if (lowest_priority !== 3'd1) begin
         tests_failed++;
         $display("FAIL rotate_over_aeoi: got L=%0d, expected 1", lowest_priority);
      end
      aeoi_rotate = 0; ir_in = 0; tick(); tick();
   endtask

   task automatic test_level_rst_mid_ack();
      ltim = 1; ir_in = 8'h40;
      tick(); tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd6) begin
         tests_failed++;
         $display("FAIL level_req: got int=%b idx=%0d, expected 1 6", int_req, highest_priority_idx);
      end
      ack1 = 1; tick(); ack1 = 0;
      tests_run++;
      if (irr !== 8'h00 || in_ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL level_ack_clear: got irr=%h ack=%b, expected 00 1", irr, in_ack);
      end
      tick();
      tests_run++;
      if (irr !== 8'h40 || int_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL level_reload: got irr=%h int=%b, expected 40 0", irr, int_req);
      end
      rst = 1; tick(); rst = 0;
      tests_run++;
      if ({irr, int_req, highest_priority_idx, lowest_priority, in_ack} !== {8'h00, 1'b0, 3'd0, 3'd7, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_mid_ack: got irr=%h int=%b idx=%0d L=%0d ack=%b, expected 00 0 0 7 0",
                  irr, int_req, highest_priority_idx, lowest_priority, in_ack);
      end
      ack2 = 1; tick(); ack2 = 0;
      tests_run++;
      if (in_ack !== 1'b0 || int_req !== 1'b0 || irr !== 8'h40) begin
         tests_failed++;
         $display("FAIL ack2_after_rst: got ack=%b int=%b irr=%h, expected 0 0 40", in_ack, int_req, irr);
      end
      tick();
      tests_run++;
      if (int_req !== 1'b1 || highest_priority_idx !== 3'd6) begin
         tests_failed++;
         $display("FAIL int_after_rst: got int=%b idx=%0d, expected 1 6", int_req, highest_priority_idx);
      end
      ack1 = 1; tick(); ack1 = 0;
      ack2 = 1; tick(); ack2 = 0;
      ltim = 0; ir_in = 0; tick(); tick();
   endtask

   task automatic test_random();
      rst = 1; model_step(); tick(); rst = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 2) == 0) ir_in = ir_in ^ (8'h01 << $urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) imr = 8'($urandom) & 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 7) == 0) isr = ($urandom_range(0, 2) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         if ($urandom_range(0, 31) == 0) special_mask_mode = ~special_mask_mode;
         if ($urandom_range(0, 63) == 0) ltim = ~ltim;
         ack1 = ($urandom_range(0, 5) == 0);
         ack2 = ($urandom_range(0, 3) == 0);
         rotate_cmd = ($urandom_range(0, 19) == 0);
         rotate_specific = 1'($urandom);
         rotate_level = 3'($urandom_range(0, 7));
         eoi_idx = 3'($urandom_range(0, 7));
         aeoi_rotate = 1'($urandom);
         rst = ($urandom_range(0, 199) == 0);
         model_step();
         tick();
         tests_run++;
         if ({irr, int_req, highest_priority_idx, lowest_priority, in_ack} !== {m_irr, m_int, m_idx, m_L, m_inack}) begin
            tests_failed++;
            $display("FAIL random_cycle_%0d: got irr=%h int=%b idx=%0d L=%0d ack=%b, expected %h %b %0d %0d %b",
                     c, irr, int_req, highest_priority_idx, lowest_priority, in_ack,
                     m_irr, m_int, m_idx, m_L, m_inack);
         end
      end
      rst = 0; ack1 = 0; ack2 = 0; rotate_cmd = 0;
   endtask

   initial begin
      rst = 1; ir_in = 0; ltim = 0; imr = 0; isr = 0; special_mask_mode = 0;
      ack1 = 0; ack2 = 0; rotate_cmd = 0; rotate_specific = 0; rotate_level = 0;
      eoi_idx = 0; aeoi_rotate = 0;
      test_reset();
      test_edge_basic();
      test_isr_block_smm();
      test_masked_spurious();
      test_rotate_specific();
      test_aeoi_rotate();
      test_level_rst_mid_ack();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pic_priority_resolver.md
Name: pic_priority_resolver

Overview:
- Upstream stage of the in-service block in the 8259 PIC.
- Captures raw IR lines into the interrupt request register (IRR) and applies the interrupt mask (IMR).
- Resolves the highest-priority unmasked request against the current in-service vector and the rotating priority base.
- Raises int_req, then freezes and presents highest_priority_idx through the two-pulse INTA sequence (ack1/ack2) that the in-service block consumes.

Parameters:
- NUM_IR, 8, number of interrupt levels (fixed at 8; other values unsupported).
- RESET_LOWEST, 3'd7, lowest-priority level after reset (IR0 highest).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ir_in  in  8  IR lines, already synchronised to clk.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered.
- imr  in  8  mask register; 1 = level masked.
- isr  in  8  interrupts_in_service from the in-service block.
- special_mask_mode  in  1  SMM enable.
- ack1  in  1  one-cycle pulse, first INTA.
- ack2  in  1  one-cycle pulse, second INTA.
- rotate_cmd  in  1  one-cycle pulse, OCW2 rotate command.
- rotate_specific  in  1  with rotate_cmd: 1 = set base to rotate_level; 0 = set base to eoi_idx.
- rotate_level  in  3  level for specific rotate.
- eoi_idx  in  3  last_serviced_idx from the in-service block.
- aeoi_rotate  in  1  rotate-on-AEOI enable.
- irr  out  8  interrupt request register.
- int_req  out  1  INT to CPU, registered.
- highest_priority_idx  out  3  resolved (frozen during INTA) level.
- lowest_priority  out  3  current rotating base L.
- in_ack  out  1  1 between accepted ack1 and ack2.

Behaviour:
- Reset values:
  - irr = 0, int_req = 0, highest_priority_idx = 0, lowest_priority = RESET_LOWEST, in_ack = 0.
  - Edge history register ir_prev = 8'hFF, so lines already high at reset release do not latch.
- IRR update, every cycle, per bit i:
  - Level mode: irr[i] <= ir_in[i].
  - Edge mode: irr[i] <= (irr[i] | (ir_in[i] & ~ir_prev[i])) & ir_in[i]. A request dropped before ack is lost.
  - ir_prev <= ir_in every cycle.
  - Switching ltim mid-run takes effect on the next cycle; no flush.
- Priority order is L+1, L+2, ..., L (mod 8). Candidate vector = irr & ~imr; p = first set candidate in rotated order.
- Blocking:
  - Normal mode: p is valid only if no isr bit of equal or higher priority (rotated order) is set.
  - SMM: p is valid iff isr[p] = 0; other isr bits do not block.
- Combinational resolve; registered outputs.
  - State IDLE: int_req <= valid; highest_priority_idx <= p when valid, else holds.
  - Latency: ir_in edge to int_req = 2 cycles (IRR register, then output register).
- State machine, states IDLE and ACK:
  - IDLE, ack1:
    - If int_req = 1: latch current highest_priority_idx as the grant, clear irr[grant] for that cycle (edge latch cleared), int_req <= 0, in_ack <= 1, go to ACK.
    - If int_req = 0 (spurious): highest_priority_idx <= 7, no IRR change, spurious flag set, go to ACK.
  - ACK: int_req held 0 and highest_priority_idx frozen regardless of IRR/ISR changes. On ack2: in_ack <= 0, go to IDLE.
  - ack2 in IDLE: ignored.
  - ack1 in ACK: ignored.
  - ack1 and ack2 in the same cycle: ack1 processed, ack2 ignored.
- Rotation; precedence is rst > rotate_cmd > AEOI rotate:
  - rotate_cmd: L <= rotate_specific ? rotate_level : eoi_idx.
  - AEOI rotate: in ACK on ack2 with aeoi_rotate = 1 and grant not spurious, L <= grant.
  - rotate_cmd and ack1 in the same cycle: grant uses old L; L updates afterwards.
- Level mode after ack1: irr[grant] reloads next cycle if the line is still high. The in-service block's isr bit then blocks re-request in normal mode.
- rst asserted mid-INTA: return to IDLE with reset values; a following ack2 is ignored.

Decomposition:
- Shared package pic_pkg:
  - PIC_NUM_IR = 8 and PIC_IDX_W = 3.
  - PIC_SPURIOUS_IDX = 3'd7 and PIC_RESET_LOWEST = 3'd7.
  - State enum {PR_IDLE, PR_ACK}.
- Sub-module pic_rotate_find_first: combinational; inputs vector[8] and base[3]; outputs found and idx[3] as the first set bit scanning base+1 upward mod 8. Used twice: once for the request scan, once for the isr block check.

Test Plan:
- Edge mode, imr = 0, L = 7, ir_in = 8'h24 rising in cycle 0 -> irr = 8'h24 at cycle 1, int_req = 1 and idx = 2 at cycle 2; ack1 -> irr = 8'h20, int_req = 0, in_ack = 1; ack2 -> in_ack = 0.
- isr = 8'h04, irr = 8'h09 -> idx = 0 granted (higher than 2) while IR3 is blocked; set SMM with isr = 8'h01 -> IR3 becomes valid.
- imr = 8'h01, ir_in = 8'h01 held -> int_req stays 0; ack1 then gives idx = 7 (spurious), irr unchanged, L unchanged after ack2 with aeoi_rotate = 1.
- rotate_cmd with rotate_specific = 1 and rotate_level = 3, then irr = 8'h11 -> idx = 4 (order 4..3), lowest_priority = 3.
- aeoi_rotate = 1, grant IR5 through ack1/ack2 -> lowest_priority = 5; rotate_cmd in the same cycle as ack2 with eoi_idx = 1 -> lowest_priority = 1.
- Level mode, ir_in[6] high; pulse rst in ACK -> all outputs at reset values; next ack2 ignored; int_req returns 2 cycles after rst deasserts.
